// File: rtl/vec_broadcast_gen_pkg.sv
// Shared vALU definitions: opcodes, element-width codes, FSM states and
// the lanes-per-beat helper used by the broadcast generator.
package vec_broadcast_gen_pkg;

    localparam logic [1:0] OP_SPLAT = 2'b00;
    localparam logic [1:0] OP_INDEX = 2'b01;
    localparam logic [1:0] OP_SMOVE = 2'b10;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic logic [3:0] lanes_per_beat(input sew_e sew);
        return 4'd8 >> sew;
    endfunction

endpackage

// File: rtl/vec_broadcast_gen_if.sv
// Command and result-beat signals of the broadcast generator.
interface vec_broadcast_gen_if #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH     = 2,
    parameter int SEW_WIDTH       = 2,
    parameter int VL_WIDTH        = 11
);
    logic [REQ_DATA_WIDTH-1:0]    in_scalar;
    logic                         in_valid;
    logic                         in_ready;
    logic [OPSEL_WIDTH-1:0]       in_opSel;
    logic [SEW_WIDTH-1:0]         in_sew;
    logic [VL_WIDTH-1:0]          in_vl;
    logic [REQ_ADDR_WIDTH-1:0]    in_addr;
    logic [RESP_DATA_WIDTH-1:0]   out_vec;
    logic [RESP_DATA_WIDTH/8-1:0] out_be;
    logic [REQ_ADDR_WIDTH-1:0]    out_addr;
    logic                         out_valid;
    logic                         out_start;
    logic                         out_end;

    modport master (
        output in_scalar, in_valid, in_opSel, in_sew, in_vl, in_addr,
        input  in_ready, out_vec, out_be, out_addr, out_valid, out_start, out_end
    );

    modport slave (
        input  in_scalar, in_valid, in_opSel, in_sew, in_vl, in_addr,
        output in_ready, out_vec, out_be, out_addr, out_valid, out_start, out_end
    );
endinterface

// File: rtl/vec_broadcast_lane.sv
// Combinational beat builder: element values and byte enables for one beat.
module vec_broadcast_lane
    import vec_broadcast_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int VL_WIDTH   = 11
) (
    input  logic [DATA_WIDTH-1:0]   scalar,
    input  logic [1:0]              op_sel,
    input  logic [1:0]              sew,
    input  logic [VL_WIDTH-1:0]     beat,
    input  logic [VL_WIDTH-1:0]     vl,
    output logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH/8-1:0] be
);
    localparam int EW = VL_WIDTH + 3;

    logic [2:0]    lane;
    logic [2:0]    byte_in;
    logic [EW-1:0] elem;
    logic [63:0]   elem_ext;
    logic [7:0]    val;
    logic          en;

    // Work byte by byte: each byte knows its lane and its offset inside the element.
    always_comb begin
        data     = '0;
        be       = '0;
        lane     = '0;
        byte_in  = '0;
        elem     = '0;
        elem_ext = '0;
        val      = '0;
        en       = 1'b0;
        for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
            lane     = 3'(b) >> sew;
            byte_in  = 3'(b) & ~(3'b111 << sew);
            elem     = ({beat, 3'b000} >> sew) + EW'(lane);
            elem_ext = 64'(elem);
            case (op_sel)
                OP_INDEX:           val = elem_ext[{byte_in, 3'b000} +: 8];
                OP_SPLAT, OP_SMOVE: val = scalar[{byte_in, 3'b000} +: 8];
                default:            val = scalar[{byte_in, 3'b000} +: 8];
            endcase
            en = (elem < EW'(vl)) && ((op_sel != OP_SMOVE) || (elem == '0));
            be[b] = en;
            data[b*8 +: 8] = en ? val : 8'h00;
        end
    end

endmodule

// File: rtl/vec_broadcast_gen.sv
// Vector element generator: expands one scalar command into a stream of
// packed result beats (splat, element index, scalar-to-element-0).
module vec_broadcast_gen
    import vec_broadcast_gen_pkg::*;
#(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH     = 2,
    parameter int SEW_WIDTH       = 2,
    parameter int VL_WIDTH        = 11
) (
    input logic clk,
    input logic rst,
    vec_broadcast_gen_if.slave bus
);
    state_e state, state_nx;

    logic [REQ_DATA_WIDTH-1:0]    cmd_scalar, sel_scalar;
    logic [OPSEL_WIDTH-1:0]       cmd_op, sel_op;
    logic [SEW_WIDTH-1:0]         cmd_sew, sel_sew;
    logic [VL_WIDTH-1:0]          cmd_vl, sel_vl;
    logic [REQ_ADDR_WIDTH-1:0]    cmd_addr, sel_addr, nx_addr;
    logic [VL_WIDTH:0]            cmd_n, sel_n, in_n;
    logic [VL_WIDTH-1:0]          beat, nx_beat;
    logic                         accept, use_new, nx_valid, nx_end;
    logic [RESP_DATA_WIDTH-1:0]   lane_data;
    logic [RESP_DATA_WIDTH/8-1:0] lane_be;

    function automatic logic [VL_WIDTH:0] beat_count(
        input logic [OPSEL_WIDTH-1:0] op,
        input logic [SEW_WIDTH-1:0]   sew,
        input logic [VL_WIDTH-1:0]    vl
    );
        logic [VL_WIDTH:0] padded;
        padded = {1'b0, vl} + (VL_WIDTH+1)'(lanes_per_beat(sew_e'(sew)) - 4'd1);
        if (vl == '0) return '0;
        if (op == OP_SMOVE) return (VL_WIDTH+1)'(1);
        return padded >> (2'd3 - sew);
    endfunction

    always_comb begin
        bus.in_ready = rst && ((state == IDLE) || (bus.out_valid && bus.out_end));
        accept       = bus.in_valid && bus.in_ready;
        in_n         = beat_count(bus.in_opSel, bus.in_sew, bus.in_vl);
    end

    // A command accepted on the last beat chains straight into its beat 0.
    always_comb begin
        state_nx = state;
        use_new  = 1'b0;
        nx_valid = 1'b0;
        nx_beat  = '0;
        unique case (state)
            IDLE: begin
                if (accept && in_n != '0) begin
                    state_nx = RUN;
                    use_new  = 1'b1;
                    nx_valid = 1'b1;
                end
            end
            RUN: begin
                if (bus.out_end) begin
                    if (accept && in_n != '0) begin
                        use_new  = 1'b1;
                        nx_valid = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    nx_valid = 1'b1;
                    nx_beat  = beat + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        sel_scalar = use_new ? bus.in_scalar : cmd_scalar;
        sel_op     = use_new ? bus.in_opSel  : cmd_op;
        sel_sew    = use_new ? bus.in_sew    : cmd_sew;
        sel_vl     = use_new ? bus.in_vl     : cmd_vl;
        sel_addr   = use_new ? bus.in_addr   : cmd_addr;
        sel_n      = use_new ? in_n          : cmd_n;
        nx_end     = ({1'b0, nx_beat} == sel_n - 1'b1);
        nx_addr    = sel_addr + REQ_ADDR_WIDTH'(nx_beat);
    end

    vec_broadcast_lane #(
        .DATA_WIDTH (REQ_DATA_WIDTH),
        .VL_WIDTH   (VL_WIDTH)
    ) u_lane (
        .scalar (sel_scalar),
        .op_sel (sel_op),
        .sew    (sel_sew),
        .beat   (nx_beat),
        .vl     (sel_vl),
        .data   (lane_data),
        .be     (lane_be)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_scalar <= '0;
            cmd_op     <= '0;
            cmd_sew    <= '0;
            cmd_vl     <= '0;
            cmd_addr   <= '0;
            cmd_n      <= '0;
        end else if (use_new) begin
            cmd_scalar <= bus.in_scalar;
            cmd_op     <= bus.in_opSel;
            cmd_sew    <= bus.in_sew;
            cmd_vl     <= bus.in_vl;
            cmd_addr   <= bus.in_addr;
            cmd_n      <= in_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_vec   <= '0;
            bus.out_be    <= '0;
            bus.out_addr  <= '0;
            bus.out_start <= 1'b0;
            bus.out_end   <= 1'b0;
        end else begin
            beat          <= nx_beat;
            bus.out_valid <= nx_valid;
            bus.out_vec   <= nx_valid ? lane_data : '0;
            bus.out_be    <= nx_valid ? lane_be : '0;
            bus.out_addr  <= nx_valid ? nx_addr : '0;
            bus.out_start <= nx_valid && use_new;
            bus.out_end   <= nx_valid && nx_end;
        end
    end

endmodule

// File: tb/tb_vec_broadcast_gen.sv
// Bench for vec_broadcast_gen: directed plan items plus random commands
// checked against an element-level reference model.
module tb_vec_broadcast_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_broadcast_gen_if bus ();

    vec_broadcast_gen dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [63:0] vec;
        logic [7:0]  be;
        logic [31:0] addr;
        logic        start;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    logic  last_acc   = 1'b0;
    int    vcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: enumerate elements 0..vl-1 and place each into its beat/lane.
    function automatic void push_cmd(input logic [63:0] sc, input logic [1:0] op_in,
                                     input logic [1:0] sew, input int vl, input logic [31:0] addr);
        int L, ew, n, op;
        logic [63:0] mask, v;
        beat_t b;
        L    = 8 >> sew;
        ew   = 8 << sew;
        op   = (op_in == 2'd3) ? 0 : int'(op_in);
        mask = (sew == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ew) - 64'd1);
        n    = (vl == 0) ? 0 : (op == 2) ? 1 : (vl + L - 1) / L;
        for (int k = 0; k < n; k++) begin
            b       = '0;
            b.addr  = addr + 32'(k);
            b.start = (k == 0);
            b.last  = (k == n - 1);
            for (int j = 0; j < L; j++) begin
                int e;
                e = k * L + j;
                if (e < vl && (op != 2 || e == 0)) begin
                    v = (op == 1) ? (64'(e) & mask) : (sc & mask);
                    b.vec = b.vec | (v << (j * ew));
                    b.be  = b.be | 8'(((1 << (ew / 8)) - 1) << (j * ew / 8));
                end
            end
            exp_q.push_back(b);
        end
    endfunction

    task automatic compare_now();
        beat_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("in_ready",  64'(bus.in_ready),  64'(rst_n && exp_q.size() <= 1));
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        chk("out_vec",   bus.out_vec,        e.vec);
        chk("out_be",    64'(bus.out_be),    64'(e.be));
        chk("out_addr",  64'(bus.out_addr),  64'(e.addr));
        chk("out_start", 64'(bus.out_start), 64'(e.start));
        chk("out_end",   64'(bus.out_end),   64'(e.last));
    endtask

    task automatic step();
        logic [63:0] sc;
        logic [1:0]  op, sew;
        int          vl;
        logic [31:0] addr;
        last_acc = bus.in_valid && rst_n && (exp_q.size() <= 1);
        sc = bus.in_scalar; op = bus.in_opSel; sew = bus.in_sew;
        vl = int'(bus.in_vl); addr = bus.in_addr;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (last_acc) push_cmd(sc, op, sew, vl, addr);
        compare_now();
    endtask

    task automatic set_cmd(input logic [63:0] sc, input logic [1:0] op, input logic [1:0] sew,
                           input logic [10:0] vl, input logic [31:0] addr, input logic valid);
        bus.in_scalar = sc;
        bus.in_opSel  = op;
        bus.in_sew    = sew;
        bus.in_vl     = vl;
        bus.in_addr   = addr;
        bus.in_valid  = valid;
    endtask

    task automatic scramble();
        set_cmd({$urandom, $urandom}, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                11'($urandom_range(0, 2047)), $urandom, 1'b0);
    endtask

    initial begin
        set_cmd('0, '0, '0, '0, '0, 1'b0);
        #2;
        compare_now();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_now();

        // Splat SEW8, vl=10
        set_cmd(64'hA5, 2'b00, 2'd0, 11'd10, 32'h40, 1'b1);
        step();
        scramble();
        chk("t1_b0_vec",   bus.out_vec, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t1_b0_be",    64'(bus.out_be), 64'hFF);
        chk("t1_b0_addr",  64'(bus.out_addr), 64'h40);
        chk("t1_b0_start", 64'(bus.out_start), 64'd1);
        step();
        chk("t1_b1_vec",   bus.out_vec, 64'h0000_0000_0000_A5A5);
        chk("t1_b1_be",    64'(bus.out_be), 64'h03);
        chk("t1_b1_addr",  64'(bus.out_addr), 64'h41);
        chk("t1_b1_end",   64'(bus.out_end), 64'd1);
        step();

        // Index SEW16, vl=6
        set_cmd(64'h0, 2'b01, 2'd1, 11'd6, 32'h100, 1'b1);
        step();
        scramble();
        chk("t2_b0_vec", bus.out_vec, 64'h0003_0002_0001_0000);
        step();
        chk("t2_b1_vec", bus.out_vec, 64'h0000_0000_0005_0004);
        chk("t2_b1_be",  64'(bus.out_be), 64'h0F);
        step();

        // Index SEW8, vl=260: element 256 wraps to 0
        set_cmd(64'h0, 2'b01, 2'd0, 11'd260, 32'h200, 1'b1);
        step();
        scramble();
        for (int i = 0; i < 32; i++) step();
        chk("t3_b32_vec", bus.out_vec, 64'h0000_0000_0302_0100);
        chk("t3_b32_be",  64'(bus.out_be), 64'h0F);
        chk("t3_b32_end", 64'(bus.out_end), 64'd1);
        step();

        // Scalar to element 0, SEW32, vl=5
        set_cmd(64'h1234_5678_9ABC_DEF0, 2'b10, 2'd2, 11'd5, 32'h300, 1'b1);
        step();
        scramble();
        chk("t4_vec",   bus.out_vec, 64'h0000_0000_9ABC_DEF0);
        chk("t4_be",    64'(bus.out_be), 64'h0F);
        chk("t4_start", 64'(bus.out_start), 64'd1);
        chk("t4_end",   64'(bus.out_end), 64'd1);
        step();

        // Back-to-back: second command held valid until accepted on end beat
        vcnt = 0;
        set_cmd(64'h1111_2222_3333_4444, 2'b00, 2'd3, 11'd2, 32'h400, 1'b1);
        step();
        vcnt += int'(bus.out_valid);
        set_cmd(64'h5555_6666_7777_8888, 2'b00, 2'd3, 11'd2, 32'h500, 1'b1);
        step();
        vcnt += int'(bus.out_valid);
        step();
        vcnt += int'(bus.out_valid);
        scramble();
        chk("b2b_start", 64'(bus.out_start), 64'd1);
        step();
        vcnt += int'(bus.out_valid);
        step();
        vcnt += int'(bus.out_valid);
        chk("b2b_cnt", 64'(vcnt), 64'd4);

        // vl=0 is accepted and dropped
        set_cmd(64'hDEAD, 2'b00, 2'd0, 11'd0, 32'h600, 1'b1);
        step();
        scramble();
        chk("vl0_ready", 64'(bus.in_ready), 64'd1);
        chk("vl0_valid", 64'(bus.out_valid), 64'd0);
        step();

        // Reset during beat 1 of 4
        set_cmd(64'hCAFE_F00D_0000_0001, 2'b00, 2'd3, 11'd4, 32'h700, 1'b1);
        step();
        scramble();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        compare_now();
        chk("rst_vec", bus.out_vec, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_now();
        step();
        step();

        // Random commands; a refused command is held until accepted
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !last_acc)) begin
                if ($urandom_range(0, 9) < 6) begin
                    int r;
                    logic [10:0] vl;
                    logic [31:0] addr;
                    r    = int'($urandom_range(0, 9));
                    vl   = (r == 0) ? 11'd0 : (r < 8) ? 11'($urandom_range(1, 24))
                                                      : 11'($urandom_range(25, 300));
                    addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                       : $urandom;
                    set_cmd({$urandom, $urandom}, 2'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3)), vl, addr, 1'b1);
                end else begin
                    scramble();
                end
            end
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 300; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
